// File: rtl/cos_sin_if.sv
// ---------------------------------------------------------------------------
// cos_sin_if
//   Request/result bundle for the cos_sin CORDIC core.
//
//   Signals
//     phase_in  [31:0]       unsigned phase word, full scale = 2*pi
//     valid_in               request strobe (sampled only while busy_out = 0)
//     busy_out               computation in flight
//     valid_out              one-cycle result strobe
//     cos_out   [WIDTH-1:0]  signed cos(phase), 1.0 = 2^(WIDTH-2)
//     sin_out   [WIDTH-1:0]  signed sin(phase), 1.0 = 2^(WIDTH-2)
//
//   Modports
//     master : requester side (drives phase_in/valid_in)
//     slave  : the cos_sin core
// ---------------------------------------------------------------------------
interface cos_sin_if #(
    parameter int WIDTH = 32
);
    logic [31:0]             phase_in;
    logic                    valid_in;
    logic                    busy_out;
    logic                    valid_out;
    logic signed [WIDTH-1:0] cos_out;
    logic signed [WIDTH-1:0] sin_out;

    modport master (
        output phase_in,
        output valid_in,
        input  busy_out,
        input  valid_out,
        input  cos_out,
        input  sin_out
    );

    modport slave (
        input  phase_in,
        input  valid_in,
        output busy_out,
        output valid_out,
        output cos_out,
        output sin_out
    );
endinterface

// File: rtl/cos_sin.sv
// ---------------------------------------------------------------------------
// cos_sin
//   Iterative rotation-mode CORDIC: phase word in, cos/sin out.
//   The top two phase bits select the quadrant; the remaining 30 bits form a
//   residual angle in [0, pi/2) that is driven to zero by ITER
//   micro-rotations, one per clock. A final cycle maps the result back into
//   the selected quadrant and registers it.
//
//   Ports
//     clk_in    : clock, rising edge
//     rst_n_in  : asynchronous active-low reset
//     bus       : cos_sin_if.slave (phase_in, valid_in, busy_out,
//                 valid_out, cos_out, sin_out)
//
//   Parameters
//     WIDTH : output width, 16..32; 1.0 = 2^(WIDTH-2)
//     ITER  : micro-rotations per result, 8..30
//
//   Timing
//     accept edge -> valid_out : ITER + 1 cycles
//     throughput               : one result per ITER + 2 cycles
//
//   Build option
//     COS_SAT_EN : when defined, each output is clamped to
//                  [-2^(WIDTH-2), +2^(WIDTH-2)] in the quadrant-fix cycle.
//                  When undefined, the low WIDTH bits pass straight through.
// ---------------------------------------------------------------------------
module cos_sin #(
    parameter int WIDTH = 32,
    parameter int ITER  = 24
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    cos_sin_if.slave   bus
);
    // x/y carry two guard bits: CORDIC gain transient and negation headroom.
    localparam int XW = WIDTH + 2;

    // K = 0.6072529350 scaled to Q30, rescaled with rounding to Q(WIDTH-2).
    localparam logic [63:0] K_Q30  = 64'd652032874;
    localparam int          K_SH   = 32 - WIDTH;
    localparam logic [63:0] K_RND  = (64'd1 << K_SH) >> 1;
    localparam logic [63:0] K_FULL = (K_Q30 + K_RND) >> K_SH;
    localparam logic signed [XW-1:0] K_INIT = K_FULL[XW-1:0];

    localparam logic [4:0] ITER_LAST = 5'(ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ROTATE = 2'd1,
        S_FIX    = 2'd2
    } state_t;

    // atan(2^-i) in phase units (2*pi = 2^32), rounded to nearest.
    function automatic logic [31:0] atan_lut(input logic [4:0] idx);
        logic [31:0] v;
        case (idx)
            5'd0:  v = 32'h2000_0000;
            5'd1:  v = 32'h12E4_051E;
            5'd2:  v = 32'h09FB_385B;
            5'd3:  v = 32'h0511_11D4;
            5'd4:  v = 32'h028B_0D43;
            5'd5:  v = 32'h0145_D7E1;
            5'd6:  v = 32'h00A2_F61E;
            5'd7:  v = 32'h0051_7C55;
            5'd8:  v = 32'h0028_BE53;
            5'd9:  v = 32'h0014_5F2F;
            5'd10: v = 32'h000A_2F98;
            5'd11: v = 32'h0005_17CC;
            5'd12: v = 32'h0002_8BE6;
            5'd13: v = 32'h0001_45F3;
            5'd14: v = 32'h0000_A2FA;
            5'd15: v = 32'h0000_517D;
            5'd16: v = 32'h0000_28BE;
            5'd17: v = 32'h0000_145F;
            5'd18: v = 32'h0000_0A30;
            5'd19: v = 32'h0000_0518;
            5'd20: v = 32'h0000_028C;
            5'd21: v = 32'h0000_0146;
            5'd22: v = 32'h0000_00A3;
            5'd23: v = 32'h0000_0051;
            5'd24: v = 32'h0000_0029;
            5'd25: v = 32'h0000_0014;
            5'd26: v = 32'h0000_000A;
            5'd27: v = 32'h0000_0005;
            5'd28: v = 32'h0000_0003;
            5'd29: v = 32'h0000_0001;
            default: v = 32'h0000_0000;
        endcase
        return v;
    endfunction

    state_t                  state_q, state_d;
    logic [4:0]              iter_q, iter_d;
    logic [1:0]              quad_q, quad_d;
    logic signed [XW-1:0]    x_q, x_d;
    logic signed [XW-1:0]    y_q, y_d;
    logic signed [32:0]      z_q, z_d;
    logic                    busy_q, busy_d;
    logic                    valid_q, valid_d;
    logic signed [WIDTH-1:0] cos_q, cos_d;
    logic signed [WIDTH-1:0] sin_q, sin_d;

    logic signed [XW-1:0]    x_sh;
    logic signed [XW-1:0]    y_sh;
    logic signed [32:0]      atan_ext;
    logic signed [XW-1:0]    c_full;
    logic signed [XW-1:0]    s_full;
    logic signed [WIDTH-1:0] c_out;
    logic signed [WIDTH-1:0] s_out;

    assign x_sh     = x_q >>> iter_q;
    assign y_sh     = y_q >>> iter_q;
    assign atan_ext = {1'b0, atan_lut(iter_q)};

    // Quadrant fold-back of the rotated vector.
    always_comb begin
        c_full = x_q;
        s_full = y_q;
        case (quad_q)
            2'd0: begin c_full = x_q;  s_full = y_q;  end
            2'd1: begin c_full = -y_q; s_full = x_q;  end
            2'd2: begin c_full = -x_q; s_full = -y_q; end
            default: begin c_full = y_q; s_full = -x_q; end
        endcase
    end

`ifdef COS_SAT_EN
    localparam logic signed [XW-1:0] ONE_P = XW'(64'sd1 <<< (WIDTH - 2));
    localparam logic signed [XW-1:0] NEG_P = -ONE_P;

    function automatic logic signed [WIDTH-1:0] clamp_out(
        input logic signed [XW-1:0] v
    );
        logic signed [XW-1:0] r;
        if (v > ONE_P)
            r = ONE_P;
        else if (v < NEG_P)
            r = NEG_P;
        else
            r = v;
        return r[WIDTH-1:0];
    endfunction

    assign c_out = clamp_out(c_full);
    assign s_out = clamp_out(s_full);
`else
    // Guard bits are dropped; residual overshoot passes through.
    logic unused_guard_bits;
    assign unused_guard_bits = ^{c_full[XW-1:WIDTH], s_full[XW-1:WIDTH]};
    assign c_out = c_full[WIDTH-1:0];
    assign s_out = s_full[WIDTH-1:0];
`endif

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        quad_d  = quad_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        cos_d   = cos_q;
        sin_d   = sin_q;

        case (state_q)
            S_IDLE: begin
                if (bus.valid_in) begin
                    quad_d  = bus.phase_in[31:30];
                    z_d     = {3'b000, bus.phase_in[29:0]};
                    x_d     = K_INIT;
                    y_d     = '0;
                    iter_d  = '0;
                    busy_d  = 1'b1;
                    state_d = S_ROTATE;
                end
            end

            S_ROTATE: begin
                // Rotate toward z = 0; sign bit of z picks the direction.
                if (!z_q[32]) begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_ext;
                end else begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_ext;
                end
                iter_d = iter_q + 5'd1;
                if (iter_q == ITER_LAST) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                cos_d   = c_out;
                sin_d   = s_out;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                iter_d  = '0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                iter_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            quad_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            cos_q   <= '0;
            sin_q   <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            quad_q  <= quad_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
        end
    end

    assign bus.busy_out  = busy_q;
    assign bus.valid_out = valid_q;
    assign bus.cos_out   = cos_q;
    assign bus.sin_out   = sin_q;

endmodule

// File: tb/tb_cos_sin.sv
// ---------------------------------------------------------------------------
// tb_cos_sin
//   Directed and random stimulus for cos_sin (WIDTH = 32, ITER = 24).
//   Expected cos/sin values come from real-valued $cos/$sin of the phase,
//   scaled to Q30, with a +-256 LSB tolerance.
// ---------------------------------------------------------------------------
module tb_cos_sin;
    localparam int WIDTH = 32;
    localparam int ITER  = 24;
    localparam int TOL   = 256;
    localparam int LAT   = ITER + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    cos_sin_if #(.WIDTH(WIDTH)) bus ();

    cos_sin #(
        .WIDTH (WIDTH),
        .ITER  (ITER)
    ) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_int(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: ideal value of cos or sin for a phase word, in Q30.
    function automatic longint ideal(input logic [31:0] p, input bit want_sin);
        real th;
        real v;
        th = real'(p) * 2.0 * 3.14159265358979323846 / 4294967296.0;
        v  = want_sin ? $sin(th) : $cos(th);
        v  = v * 1073741824.0;
        return longint'($rtoi($floor(v + 0.5)));
    endfunction

    task automatic check_near(input string tag, input logic [31:0] p,
                              input logic signed [31:0] obs, input bit want_sin);
        longint e;
        longint d;
        logic   ok;
        e  = ideal(p, want_sin);
        d  = longint'(obs) - e;
        ok = (d <= TOL) && (d >= -TOL);
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL %s phase=%08h: observed %0d expected %0d +-%0d",
                   tag, p, obs, e, TOL);
        end
    endtask

    task automatic check_result(input string tag, input logic [31:0] p);
        $display("txn %s phase=%08h cos=%08h sin=%08h", tag, p, bus.cos_out, bus.sin_out);
        check_near({tag, "_cos"}, p, bus.cos_out, 1'b0);
        check_near({tag, "_sin"}, p, bus.sin_out, 1'b1);
`ifdef COS_SAT_EN
        begin
            longint c;
            longint s;
            logic   ok;
            c  = longint'(bus.cos_out);
            s  = longint'(bus.sin_out);
            ok = (c <= 64'sd1073741824) && (c >= -64'sd1073741824) &&
                 (s <= 64'sd1073741824) && (s >= -64'sd1073741824);
            checks++;
            assert (ok === 1'b1) else begin
                errors++;
                $error("FAIL %s_sat phase=%08h: observed cos %0d sin %0d expected |v| <= 2^30",
                       tag, p, c, s);
            end
        end
`endif
    endtask

    // Present one request for one cycle; returns after the accepting edge.
    task automatic start_req(input logic [31:0] p);
        bus.phase_in = p;
        bus.valid_in = 1'b1;
        step();
        bus.valid_in = 1'b0;
    endtask

    // Wait (bounded) for valid_out; lat counts edges after the accept edge.
    task automatic wait_result(output int lat, output bit busy_ok);
        busy_ok = (bus.busy_out === 1'b1);
        lat = 0;
        while (bus.valid_out !== 1'b1 && lat < 4 * LAT) begin
            step();
            lat++;
            if (bus.valid_out !== 1'b1 && bus.busy_out !== 1'b1)
                busy_ok = 1'b0;
        end
    endtask

    task automatic full_txn(input string tag, input logic [31:0] p, input bit chk_lat);
        int lat;
        bit bok;
        start_req(p);
        wait_result(lat, bok);
        if (chk_lat) begin
            check_int({tag, "_latency"}, lat, LAT);
            check_int({tag, "_busy_during"}, bok, 1);
            check_int({tag, "_busy_at_valid"}, bus.busy_out, 0);
        end
        check_result(tag, p);
    endtask

    initial begin
        int lat;
        bit bok;
        int pulses;
        logic [31:0] p;
        logic [31:0] pa;
        logic [31:0] pb;

        bus.phase_in = '0;
        bus.valid_in = 1'b0;

        // Reset state
        repeat (3) step();
        check_int("rst_busy",  bus.busy_out,  0);
        check_int("rst_valid", bus.valid_out, 0);
        check_int("rst_cos",   bus.cos_out,   0);
        check_int("rst_sin",   bus.sin_out,   0);
        rst_n = 1'b1;
        step();

        // Directed phases
        full_txn("ph_0",      32'h0000_0000, 1'b1);
        check_near("ph_0_cos_exact", 32'h0, bus.cos_out, 1'b0);
        full_txn("ph_90",     32'h4000_0000, 1'b1);
        full_txn("ph_180",    32'h8000_0000, 1'b1);
        full_txn("ph_60",     32'h2AAA_AAAB, 1'b1);
        full_txn("ph_m60",    32'hD555_5555, 1'b1);
        full_txn("ph_270",    32'hC000_0000, 1'b1);
        full_txn("ph_max",    32'hFFFF_FFFF, 1'b1);

        // Request during busy is ignored
        pa = 32'h1234_5678;
        pb = 32'hA987_6543;
        start_req(pa);
        repeat (5) step();
        bus.phase_in = pb;
        bus.valid_in = 1'b1;
        step();
        bus.valid_in = 1'b0;
        wait_result(lat, bok);
        check_int("ignore_latency", lat, LAT - 6);
        check_result("ignore", pa);
        pulses = 0;
        repeat (LAT + 4) begin
            step();
            if (bus.valid_out === 1'b1) pulses++;
        end
        check_int("ignore_no_second", pulses, 0);

        // Back-to-back: new request on the valid_out cycle
        pa = 32'h0F00_0000;
        pb = 32'h7123_4567;
        start_req(pa);
        wait_result(lat, bok);
        check_int("b2b_first_latency", lat, LAT);
        check_result("b2b_first", pa);
        bus.phase_in = pb;
        bus.valid_in = 1'b1;
        step();
        bus.valid_in = 1'b0;
        wait_result(lat, bok);
        check_int("b2b_second_latency", lat, LAT);
        check_int("b2b_second_busy", bok, 1);
        check_result("b2b_second", pb);

        // Asynchronous reset in the middle of a computation
        start_req(32'h3000_0000);
        repeat (10) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_int("midrst_busy",  bus.busy_out,  0);
        check_int("midrst_valid", bus.valid_out, 0);
        check_int("midrst_cos",   bus.cos_out,   0);
        check_int("midrst_sin",   bus.sin_out,   0);
        step();
        step();
        rst_n = 1'b1;
        pulses = 0;
        repeat (2 * LAT) begin
            step();
            if (bus.valid_out === 1'b1) pulses++;
        end
        check_int("midrst_no_valid", pulses, 0);
        check_int("midrst_idle_busy", bus.busy_out, 0);
        full_txn("after_rst", 32'h5555_5555, 1'b1);

        // Random phases
        for (int i = 0; i < 48; i++) begin
            p = $urandom;
            full_txn("rand", p, 1'b1);
        end

        // Coarse sweep across the full circle
        for (int k = 0; k < 256; k++) begin
            p = 32'(k) << 24;
            full_txn("sweep", p, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: observed no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
